// File: rtl/dmux_dispatch.sv
// dmux_dispatch: one-entry buffered dispatcher steering producer words
// to N_OUT sinks, addressed or round-robin, with stall-timeout drop.
module dmux_dispatch #(
    parameter int WIDTH   = 16,
    parameter int N_OUT   = 4,
    parameter int TIMEOUT = 16,
    localparam int DW     = $clog2(N_OUT)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_mode,
    input  logic [DW-1:0]    i_dest,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [N_OUT-1:0] o_valid,
    input  logic [N_OUT-1:0] i_ready,
    output logic             o_drop,
    output logic [7:0]       o_drop_cnt
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [DW-1:0]    dest_q, dest_d;
    logic [CW-1:0]    wait_q, wait_d;
    logic [DW-1:0]    rr_q, rr_d;
    logic [7:0]       cnt_q, cnt_d;

    logic xfer;
    logic drop;
    logic rdy;
    logic accept;

    // Handshake decode, refill/drain of the holding register, drop count
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        dest_d  = dest_q;
        wait_d  = wait_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;

        xfer   = (state_q == FULL) && i_ready[dest_q];
        drop   = (state_q == FULL) && !xfer && (TIMEOUT != 0)
                 && (wait_q == LAST);
        rdy    = i_rst_n && ((state_q == EMPTY) || xfer || drop);
        accept = i_valid && rdy;

        if (accept) begin
            state_d = FULL;
            data_d  = i_data;
            dest_d  = i_mode ? rr_q : i_dest;
            wait_d  = '0;
            if (i_mode) begin
                rr_d = rr_q + 1'b1;
            end
        end else if (xfer || drop) begin
            state_d = EMPTY;
            wait_d  = '0;
        end else if ((state_q == FULL) && (TIMEOUT != 0)) begin
            wait_d = wait_q + 1'b1;
        end

        if (drop && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // State register; reset discards any held word without a drop pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            dest_q  <= '0;
            wait_q  <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            dest_q  <= dest_d;
            wait_q  <= wait_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs: shared data bus, one-hot valid toward the held destination
    always_comb begin
        o_ready    = rdy;
        o_data     = data_q;
        o_valid    = (state_q == FULL) ? (N_OUT'(1) << dest_q) : '0;
        o_drop     = drop;
        o_drop_cnt = cnt_q;
    end

endmodule

// File: tb/tb_dmux_dispatch.sv
// tb_dmux_dispatch: table vectors, directed corner sequences and random
// stimulus against a transaction-level model of the dispatcher.
module tb_dmux_dispatch;

    localparam int T_A = 8;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        mode, valid;
    logic [1:0]  dest;
    logic [15:0] data;
    logic [3:0]  rdy;
    logic        o_ready, o_drop;
    logic [15:0] o_data;
    logic [3:0]  o_valid;
    logic [7:0]  o_drop_cnt;

    logic        mode_b, valid_b;
    logic [1:0]  dest_b;
    logic [15:0] data_b;
    logic [3:0]  rdy_b;
    logic        o_ready_b, o_drop_b;
    logic [15:0] o_data_b;
    logic [3:0]  o_valid_b;
    logic [7:0]  o_drop_cnt_b;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    dmux_dispatch #(.WIDTH(16), .N_OUT(4), .TIMEOUT(T_A)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_mode(mode), .i_dest(dest),
        .i_data(data), .i_valid(valid), .o_ready(o_ready),
        .o_data(o_data), .o_valid(o_valid), .i_ready(rdy),
        .o_drop(o_drop), .o_drop_cnt(o_drop_cnt)
    );

    dmux_dispatch #(.WIDTH(16), .N_OUT(4), .TIMEOUT(1)) u_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_mode(mode_b), .i_dest(dest_b),
        .i_data(data_b), .i_valid(valid_b), .o_ready(o_ready_b),
        .o_data(o_data_b), .o_valid(o_valid_b), .i_ready(rdy_b),
        .o_drop(o_drop_b), .o_drop_cnt(o_drop_cnt_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a word is either held or not; its age is
    // the number of cycles it has been offered so far.
    bit m_full;
    int m_data, m_dest, m_age, m_rr, m_cnt;
    bit last_acc;

    task automatic model_reset();
        m_full = 0; m_data = 0; m_dest = 0;
        m_age = 0; m_rr = 0; m_cnt = 0;
    endtask

    task automatic cycle(input bit v, input bit md, input int d,
                         input int w, input int r);
        bit xf, dr, rd;
        int ev;
        @(negedge clk);
        valid = v; mode = md; dest = d[1:0]; data = w[15:0]; rdy = r[3:0];
        #1;
        xf = m_full && r[m_dest];
        dr = m_full && !xf && (m_age == T_A);
        rd = !m_full || xf || dr;
        ev = m_full ? (1 << m_dest) : 0;
        chk("m_ready", o_ready, rd);
        chk("m_valid", o_valid, ev);
        if (m_full) chk("m_data", o_data, m_data);
        chk("m_drop", o_drop, dr);
        chk("m_drop_cnt", o_drop_cnt, m_cnt);
        last_acc = v && rd;
        if (dr && m_cnt < 255) m_cnt++;
        if (v && rd) begin
            m_full = 1;
            m_data = w & 'hFFFF;
            m_dest = md ? m_rr : (d & 3);
            m_age  = 1;
            if (md) m_rr = (m_rr + 1) % 4;
        end else if (xf || dr) begin
            m_full = 0;
        end else if (m_full) begin
            m_age++;
        end
    endtask

    typedef struct {
        bit v; bit md; int d; int w; int r;
        bit er; int ev; int ed;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int pv, pm, pd, pw, pr;
        tbl[0]  = '{1, 0, 2, 'h1111, 'hF, 1, 'b0000, 0};
        tbl[1]  = '{1, 0, 0, 'h2222, 'hF, 1, 'b0100, 'h1111};
        tbl[2]  = '{1, 0, 3, 'h3333, 'hF, 1, 'b0001, 'h2222};
        tbl[3]  = '{1, 1, 0, 'hA000, 'hF, 1, 'b1000, 'h3333};
        tbl[4]  = '{1, 1, 0, 'hA001, 'hF, 1, 'b0001, 'hA000};
        tbl[5]  = '{1, 1, 0, 'hA002, 'hF, 1, 'b0010, 'hA001};
        tbl[6]  = '{1, 1, 0, 'hA003, 'hF, 1, 'b0100, 'hA002};
        tbl[7]  = '{1, 1, 0, 'hA004, 'hF, 1, 'b1000, 'hA003};
        tbl[8]  = '{1, 1, 0, 'hA005, 'hF, 1, 'b0001, 'hA004};
        tbl[9]  = '{1, 0, 3, 'hB000, 'hF, 1, 'b0010, 'hA005};
        tbl[10] = '{1, 0, 1, 'hB001, 'hF, 1, 'b1000, 'hB000};
        tbl[11] = '{1, 1, 0, 'hC000, 'hF, 1, 'b0010, 'hB001};
        tbl[12] = '{0, 0, 0, 0,      'hF, 1, 'b0100, 'hC000};
        tbl[13] = '{0, 0, 0, 0,      'hF, 1, 'b0000, 0};

        rst_n = 1'b0;
        valid = 0; mode = 0; dest = 0; data = 0; rdy = 0;
        valid_b = 0; mode_b = 0; dest_b = 2'd3; data_b = 0; rdy_b = 0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_ready", o_ready, 0);
        chk("rst_drop", o_drop, 0);
        chk("rst_data", o_data, 0);
        chk("rst_cnt", o_drop_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", o_ready, 1);

        // Addressed stream, round-robin, mode switch
        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].v, tbl[i].md, tbl[i].d, tbl[i].w, tbl[i].r);
            chk($sformatf("tbl%0d_ready", i), o_ready, tbl[i].er);
            chk($sformatf("tbl%0d_valid", i), o_valid, tbl[i].ev);
            if (tbl[i].ev != 0)
                chk($sformatf("tbl%0d_data", i), o_data, tbl[i].ed);
        end

        // Backpressure on sink 1 with a pending word for sink 0
        cycle(1, 0, 1, 'h5151, 'b0001);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0, 'h6262, 'b0001);
            chk("bp_stall_ready", o_ready, 0);
            chk("bp_stall_valid", o_valid, 'b0010);
        end
        cycle(1, 0, 0, 'h6262, 'b0011);
        chk("bp_accept_ready", o_ready, 1);
        cycle(0, 0, 0, 0, 'b0001);
        chk("bp_next_valid", o_valid, 'b0001);
        chk("bp_next_data", o_data, 'h6262);
        cycle(0, 0, 0, 0, 'b0000);
        chk("bp_idle_valid", o_valid, 0);

        // Timeout to a dead sink 3
        cycle(1, 0, 3, 'h8888, 0);
        for (int i = 1; i <= 8; i++) begin
            cycle(0, 0, 0, 0, 0);
            chk($sformatf("to_valid%0d", i), o_valid, 'b1000);
            chk($sformatf("to_drop%0d", i), o_drop, int'(i == 8));
        end
        cycle(0, 0, 0, 0, 0);
        chk("to_after_valid", o_valid, 0);
        chk("to_after_cnt", o_drop_cnt, 1);

        // Sink becomes ready in the last offered cycle: transfer wins
        cycle(1, 0, 3, 'h9999, 0);
        for (int i = 1; i <= 8; i++) begin
            cycle(0, 0, 0, 0, (i == 8) ? 'b1000 : 0);
            chk($sformatf("tx_valid%0d", i), o_valid, 'b1000);
            chk($sformatf("tx_drop%0d", i), o_drop, 0);
        end
        cycle(0, 0, 0, 0, 0);
        chk("tx_after_valid", o_valid, 0);
        chk("tx_after_cnt", o_drop_cnt, 1);

        // Reset lands in the cycle a drop would fire
        cycle(1, 1, 0, 'h7777, 0);
        for (int i = 1; i <= 7; i++) cycle(0, 0, 0, 0, 0);
        @(negedge clk);
        valid = 0; rdy = 0;
        #1;
        chk("mr_pre_drop", o_drop, 1);
        rst_n = 1'b0;
        #1;
        chk("mr_valid", o_valid, 0);
        chk("mr_ready", o_ready, 0);
        chk("mr_drop", o_drop, 0);
        chk("mr_cnt", o_drop_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mr_rel_ready", o_ready, 1);
        chk("mr_rel_cnt", o_drop_cnt, 0);
        model_reset();
        cycle(1, 1, 0, 'h4444, 'hF);
        cycle(0, 0, 0, 0, 'hF);
        chk("mr_rr_restart", o_valid, 'b0001);

        // Random traffic; producer holds its word until accepted
        last_acc = 1;
        pv = 0; pm = 0; pd = 0; pw = 0;
        for (int n = 0; n < 600; n++) begin
            if (!(pv != 0 && !last_acc)) begin
                pv = ($urandom_range(0, 3) != 0) ? 1 : 0;
                pm = $urandom_range(0, 1);
                pd = $urandom_range(0, 3);
                pw = $urandom_range(0, 'hFFFF);
            end
            pr = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 15);
            cycle(pv[0], pm[0], pd, pw, pr);
        end

        // Saturation with TIMEOUT=1: every cycle drops and refills
        for (int i = 0; i < 262; i++) begin
            @(negedge clk);
            valid_b = 1; data_b = i[15:0];
            #1;
            chk("sat_ready", o_ready_b, 1);
            chk("sat_drop", o_drop_b, int'(i > 0));
        end
        @(negedge clk);
        valid_b = 0;
        #1;
        chk("sat_cnt", o_drop_cnt_b, 255);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
